layer1_input_packer: RTL

LAYER1_INPUT_PACKER -- requirements
Module: layer1_input_packer

---
 rtl/layer1_input_packer_pkg.sv | 13 +
 rtl/layer1_input_packer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/layer1_input_packer_pkg.sv
// Shared layer-1 definitions: default input geometry and the packer FSM states.
package layer1_input_packer_pkg;

  localparam int DEF_NUM_FEATURES = 3;
  localparam int DEF_FEAT_BITS    = 2;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } pack_state_e;

endpackage

// File: rtl/layer1_input_packer.sv
// Packs a framed stream of quantized features into one fan-in vector for the
// first-layer neuron LUTs, with framing-error detection and resync.
//
// state | meaning
// FILL  | accepting feature beats, building the vector
// HOLD  | complete vector parked behind a stalled output, input stalled
// DROP  | discarding beats of a malformed frame until its s_last
module layer1_input_packer
  import layer1_input_packer_pkg::*;
#(
  parameter int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int FEAT_BITS    = DEF_FEAT_BITS,
  localparam int VEC_W       = NUM_FEATURES * FEAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [FEAT_BITS-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [VEC_W-1:0]     m_data,
  output logic                 err
);

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int LOW_W = VEC_W - FEAT_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  pack_state_e      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [LOW_W-1:0] acc, acc_nxt;
  logic [VEC_W-1:0] hold, hold_nxt;
  logic [VEC_W-1:0] m_data_nxt;
  logic [VEC_W-1:0] done_vec;
  logic             m_valid_nxt;
  logic             err_nxt;
  logic             accept;
  logic             slot_free;

  assign s_ready   = (state != ST_HOLD);
  assign accept    = s_valid && s_ready;
  assign slot_free = !m_valid || m_ready;
  // The final feature goes straight from the bus into the top slice.
  assign done_vec  = {s_data, acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FILL;
      idx     <= '0;
      acc     <= '0;
      hold    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      acc     <= acc_nxt;
      hold    <= hold_nxt;
      m_valid <= m_valid_nxt;
      m_data  <= m_data_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    acc_nxt     = acc;
    hold_nxt    = hold;
    m_valid_nxt = m_valid;
    m_data_nxt  = m_data;
    err_nxt     = 1'b0;

    if (m_valid && m_ready) m_valid_nxt = 1'b0;

    case (state)
      ST_FILL: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (!s_last) begin
              err_nxt   = 1'b1;
              state_nxt = ST_DROP;
            end else if (slot_free) begin
              m_data_nxt  = done_vec;
              m_valid_nxt = 1'b1;
            end else begin
              hold_nxt  = done_vec;
              state_nxt = ST_HOLD;
            end
          end else if (s_last) begin
            err_nxt = 1'b1;
            idx_nxt = '0;
          end else begin
            acc_nxt[int'(idx)*FEAT_BITS +: FEAT_BITS] = s_data;
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // m_valid is necessarily high here, so m_ready alone is the handshake.
        if (m_ready) begin
          m_data_nxt  = hold;
          m_valid_nxt = 1'b1;
          state_nxt   = ST_FILL;
        end
      end
      ST_DROP: begin
        if (accept && s_last) begin
          state_nxt = ST_FILL;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_FILL;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule
